// File: rtl/spimem_arbiter.sv
`timescale 1ns/1ps
// Shares the spimemio read port and cfgreg port between instruction fetch,
// data load and a config-register writer, with a per-grant watchdog.
module spimem_arbiter #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_we,
  input  logic [31:0]       cfg_di,
  output logic              cfg_ready,
  output logic [31:0]       cfg_do,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,
  output logic [3:0]        m_cfgreg_we,
  output logic [31:0]       m_cfgreg_di,
  input  logic [31:0]       m_cfgreg_do,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned       WD_W   = 8;
  localparam logic [WD_W-1:0]   WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    CFG   = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic              last_d, last_d_nx;
  logic [WD_W-1:0]   wdog, wdog_nx;
  logic              gnt_valid;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_done;
  logic [31:0]       gnt_data;

  // State, round-robin history and watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b1;
      wdog   <= '0;
    end else begin
      state  <= state_nx;
      last_d <= last_d_nx;
      wdog   <= wdog_nx;
    end
  end

  assign busy   = (state != IDLE);
  assign cfg_do = m_cfgreg_do;

  // Next-state and port muxing
  always_comb begin
    state_nx    = state;
    last_d_nx   = last_d;
    wdog_nx     = wdog;
    m_valid     = 1'b0;
    m_addr      = '0;
    m_cfgreg_we = '0;
    m_cfgreg_di = '0;
    cfg_ready   = 1'b0;
    timeout_err = 1'b0;
    gnt_done    = 1'b0;
    gnt_data    = m_rdata;
    gnt_valid   = (state == GNT_D) ? d_valid : i_valid;
    gnt_addr    = (state == GNT_D) ? d_addr  : i_addr;

    case (state)
      IDLE: begin
        if (cfg_valid && (cfg_we != 4'b0000)) begin
          state_nx = CFG;
        end else if (i_valid && d_valid) begin
          state_nx = last_d ? GNT_I : GNT_D;
        end else if (i_valid) begin
          state_nx = GNT_I;
        end else if (d_valid) begin
          state_nx = GNT_D;
        end
        // An all-zero byte-enable write is acknowledged without touching the flash
        cfg_ready = cfg_valid && (cfg_we == 4'b0000);
      end

      GNT_I, GNT_D: begin
        m_valid = gnt_valid;
        m_addr  = gnt_addr;
        if (m_ready) begin
          gnt_done  = 1'b1;
          state_nx  = IDLE;
          wdog_nx   = '0;
          last_d_nx = (state == GNT_D);
        end else if (!gnt_valid) begin
          state_nx = IDLE;
          wdog_nx  = '0;
        end else if (wdog == WD_MAX) begin
          gnt_done    = 1'b1;
          gnt_data    = ERR_DATA;
          timeout_err = 1'b1;
          state_nx    = IDLE;
          wdog_nx     = '0;
          last_d_nx   = (state == GNT_D);
        end else begin
          wdog_nx = wdog + WD_W'(1);
        end
      end

      CFG: begin
        m_cfgreg_we = cfg_we;
        m_cfgreg_di = cfg_di;
        cfg_ready   = 1'b1;
        state_nx    = IDLE;
      end
    endcase

    i_ready = gnt_done && (state == GNT_I);
    d_ready = gnt_done && (state == GNT_D);
    i_rdata = gnt_data;
    d_rdata = gnt_data;

    // A grant caught by reset ends silently
    if (reset) begin
      m_valid     = 1'b0;
      m_cfgreg_we = '0;
      cfg_ready   = 1'b0;
      timeout_err = 1'b0;
      i_ready     = 1'b0;
      d_ready     = 1'b0;
    end
  end

endmodule

// File: tb/tb_spimem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for spimem_arbiter: two instances, the second with a
// short watchdog, each driven by a simple spimemio latency model.
module tb_spimem_arbiter;
  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid, d_valid, cfg_valid;
  logic [AW-1:0] i_addr, d_addr;
  logic [3:0]    cfg_we;
  logic [31:0]   cfg_di;
  logic [31:0]   m_cfgreg_do;

  logic          i_ready, d_ready, cfg_ready, m_valid, busy, timeout_err;
  logic [31:0]   i_rdata, d_rdata, cfg_do, m_cfgreg_di;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_cfgreg_we;
  logic          m_ready = 1'b0;
  logic [31:0]   m_rdata;

  logic          t_i_ready, t_d_ready, t_cfg_ready, t_m_valid, t_busy, t_timeout_err;
  logic [31:0]   t_i_rdata, t_d_rdata, t_cfg_do, t_m_cfgreg_di;
  logic [AW-1:0] t_m_addr;
  logic [3:0]    t_m_cfgreg_we;
  logic          t_m_ready = 1'b0;
  logic [31:0]   t_m_rdata;

  int checks = 0;
  int errors = 0;
  int lat1 = 20;
  int lat2 = 4;
  bit en2 = 1'b0;
  int cnt1 = 0;
  int cnt2 = 0;
  int icnt = 0;
  int dcnt = 0;
  bit          who_q[$];
  logic [31:0] dat_q[$];

  always #5 clk = ~clk;

  spimem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready), .d_rdata(d_rdata),
    .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_di(cfg_di),
    .cfg_ready(cfg_ready), .cfg_do(cfg_do),
    .m_valid(m_valid), .m_addr(m_addr), .m_ready(m_ready), .m_rdata(m_rdata),
    .m_cfgreg_we(m_cfgreg_we), .m_cfgreg_di(m_cfgreg_di), .m_cfgreg_do(m_cfgreg_do),
    .busy(busy), .timeout_err(timeout_err)
  );

  spimem_arbiter #(.TIMEOUT(16)) dut_to (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(t_i_ready), .i_rdata(t_i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(t_d_ready), .d_rdata(t_d_rdata),
    .cfg_valid(cfg_valid), .cfg_we(cfg_we), .cfg_di(cfg_di),
    .cfg_ready(t_cfg_ready), .cfg_do(t_cfg_do),
    .m_valid(t_m_valid), .m_addr(t_m_addr), .m_ready(t_m_ready), .m_rdata(t_m_rdata),
    .m_cfgreg_we(t_m_cfgreg_we), .m_cfgreg_di(t_m_cfgreg_di), .m_cfgreg_do(m_cfgreg_do),
    .busy(t_busy), .timeout_err(t_timeout_err)
  );

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return {8'h5A, a} ^ 32'h0000_3C3C;
  endfunction

  // spimemio stand-ins: m_ready for one cycle once m_valid has been seen lat times
  always @(negedge clk) begin
    if (m_valid && !m_ready) begin
      cnt1 = cnt1 + 1;
      if (cnt1 >= lat1) begin
        m_ready = 1'b1;
        m_rdata = mdata(m_addr);
      end
    end else begin
      m_ready = 1'b0;
      cnt1    = 0;
    end
  end

  always @(negedge clk) begin
    if (en2 && t_m_valid && !t_m_ready) begin
      cnt2 = cnt2 + 1;
      if (cnt2 >= lat2) begin
        t_m_ready = 1'b1;
        t_m_rdata = mdata(t_m_addr);
      end
    end else begin
      t_m_ready = 1'b0;
      cnt2      = 0;
    end
  end

  // Log every ready pulse of the main instance in order
  always begin
    @(negedge clk);
    #1;
    if (i_ready) begin
      icnt = icnt + 1;
      who_q.push_back(1'b0);
      dat_q.push_back(i_rdata);
    end
    if (d_ready) begin
      dcnt = dcnt + 1;
      who_q.push_back(1'b1);
      dat_q.push_back(d_rdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    icnt = 0;
    dcnt = 0;
    who_q.delete();
    dat_q.delete();
  endtask

  task automatic do_reset();
    i_valid = 1'b0; d_valid = 1'b0; cfg_valid = 1'b0;
    i_addr = '0; d_addr = '0; cfg_we = 4'b0000; cfg_di = 32'h0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d expected %0d", 0, 1);
    $fatal(1);
  end

  initial begin
    int k;
    int bad;
    logic [31:0] got_w;
    m_cfgreg_do = 32'h1234_5678;
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_ready", {i_ready, d_ready, cfg_ready}, 0);
    check("rst_cfgwe", m_cfgreg_we, 0);
    check("rst_cfgdi", m_cfgreg_di, 0);
    check("rst_toerr", timeout_err, 0);

    // Single instruction fetch, 20-cycle flash latency
    i_valid = 1'b1; i_addr = 24'h100000;
    step();
    check("t1_mvalid", m_valid, 1);
    check("t1_maddr", m_addr, 32'h0010_0000);
    check("t1_dready", d_ready, 0);
    k = 1;
    while (!i_ready && k < 100) begin
      step();
      k = k + 1;
    end
    check("t1_lat", k, 20);
    check("t1_rdata", i_rdata, mdata(24'h100000));
    after_edge();
    i_valid = 1'b0;
    step();
    check("t1_busy", busy, 0);
    check("t1_icnt", icnt, 1);

    // Continuous I and D requests alternate, I first
    do_reset();
    lat1 = 3;
    i_valid = 1'b1; i_addr = 24'h000200;
    d_valid = 1'b1; d_addr = 24'h000400;
    k = 0;
    while (who_q.size() < 4 && k < 200) begin
      step();
      k = k + 1;
    end
    after_edge();
    i_valid = 1'b0; d_valid = 1'b0;
    step();
    step();
    for (int n = 0; n < 4; n++) begin
      got_w = (n < who_q.size()) ? {31'b0, who_q[n]} : 32'hEEEE_EEEE;
      check($sformatf("t2_who%0d", n), got_w, (n % 2 == 0) ? 32'd0 : 32'd1);
      got_w = (n < dat_q.size()) ? dat_q[n] : 32'hEEEE_EEEE;
      check($sformatf("t2_dat%0d", n), got_w,
            (n % 2 == 0) ? mdata(24'h000200) : mdata(24'h000400));
    end
    check("t2_icnt", icnt, 2);
    check("t2_dcnt", dcnt, 2);

    // Config write waits for the running D grant, then one IDLE, then CFG
    do_reset();
    lat1 = 5;
    d_valid = 1'b1; d_addr = 24'h000800;
    step();
    check("t3_gntd", busy, 1);
    cfg_valid = 1'b1; cfg_we = 4'b1000; cfg_di = 32'h0000_0000;
    k = 0; bad = 0;
    while (!d_ready && k < 50) begin
      step();
      k = k + 1;
      if (m_cfgreg_we != 4'b0000 || cfg_ready) bad = bad + 1;
    end
    check("t3_no_preempt", bad, 0);
    check("t3_dready", d_ready, 1);
    after_edge();
    d_valid = 1'b0;
    step();
    check("t3_idle_busy", busy, 0);
    check("t3_idle_we", m_cfgreg_we, 0);
    step();
    check("t3_cfg_we", m_cfgreg_we, 32'h8);
    check("t3_cfg_ready", cfg_ready, 1);
    check("t3_cfg_mvalid", m_valid, 0);
    check("t3_cfg_di", m_cfgreg_di, 32'h0);
    after_edge();
    cfg_valid = 1'b0; cfg_we = 4'b0000;
    step();
    check("t3_after_busy", busy, 0);
    check("t3_after_we", m_cfgreg_we, 0);
    check("t3_cfg_do", cfg_do, 32'h1234_5678);

    // Watchdog (TIMEOUT=16) fires on the 17th grant cycle
    do_reset();
    en2 = 1'b0;
    i_valid = 1'b1; i_addr = 24'h000040;
    step();
    check("t4_busy", t_busy, 1);
    k = 1;
    while (!t_i_ready && k < 100) begin
      check("t4_early_err", t_timeout_err, 0);
      step();
      k = k + 1;
    end
    check("t4_cycle", k, 17);
    check("t4_rdata", t_i_rdata, 32'hFFFF_FFFF);
    check("t4_toerr", t_timeout_err, 1);
    after_edge();
    i_valid = 1'b0;
    step();
    check("t4_idle", t_busy, 0);
    check("t4_err_pulse", t_timeout_err, 0);
    en2 = 1'b1;
    i_valid = 1'b1; i_addr = 24'h000044;
    k = 0;
    while (!t_i_ready && k < 50) begin
      step();
      k = k + 1;
    end
    check("t4_next_ready", t_i_ready, 1);
    check("t4_next_rdata", t_i_rdata, mdata(24'h000044));
    check("t4_next_err", t_timeout_err, 0);
    after_edge();
    i_valid = 1'b0;
    step();

    // Reset during a D grant; pending I wins afterwards
    do_reset();
    lat1 = 10;
    d_valid = 1'b1; d_addr = 24'h000900;
    step();
    check("t5_gntd_addr", m_addr, 32'h0000_0900);
    i_valid = 1'b1; i_addr = 24'h000300;
    step();
    reset = 1'b1;
    after_edge();
    reset = 1'b0;
    step();
    check("t5_busy", busy, 0);
    check("t5_mvalid", m_valid, 0);
    check("t5_ready", {i_ready, d_ready, cfg_ready, timeout_err}, 0);
    check("t5_maddr", m_addr, 0);
    step();
    check("t5_gnt_i", m_addr, 32'h0000_0300);
    check("t5_gnt_valid", m_valid, 1);
    check("t5_no_dready", dcnt, 0);
    k = 0;
    while (!i_ready && k < 50) begin
      step();
      k = k + 1;
    end
    check("t5_iready", i_ready, 1);
    after_edge();
    i_valid = 1'b0; d_valid = 1'b0;
    step();
    step();

    // Zero byte-enable config write is acked in IDLE without a write
    do_reset();
    cfg_valid = 1'b1; cfg_we = 4'b0000; cfg_di = 32'hDEAD_BEEF;
    #1;
    check("t6_ready", cfg_ready, 1);
    check("t6_we", m_cfgreg_we, 0);
    step();
    check("t6_no_cfg", busy, 0);
    check("t6_we_hold", m_cfgreg_we, 0);
    cfg_valid = 1'b0;
    step();
    check("t6_ready_off", cfg_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spimem_arbiter.md
Name: spimem_arbiter

Overview:
- Shares the single spimemio read port and its cfgreg port between three requesters: instruction fetch (i_*), data load (d_*) and a config-register writer (cfg_*).
- Sits between the PicoRV32 bus split and spimemio.
- Arbitrates round-robin between I and D, gives cfg writes top priority, and only issues them while the flash port is idle.
- Bounds every flash grant with a watchdog so a stalled flash cannot hang the CPU.

Parameters:
- ADDR_W, 24, width of the flash byte address.
- TIMEOUT, 255, maximum cycles a grant may wait for m_ready (1..255).
- ERR_DATA, 32'hFFFF_FFFF, read data returned on timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- i_valid  in  1  instruction read request, held until i_ready
- i_addr  in  ADDR_W  instruction byte address (word aligned)
- i_ready  out  1  instruction read complete
- i_rdata  out  32  instruction read data
- d_valid  in  1  data read request, held until d_ready
- d_addr  in  ADDR_W  data byte address (word aligned)
- d_ready  out  1  data read complete
- d_rdata  out  32  data read data
- cfg_valid  in  1  config write request, held until cfg_ready
- cfg_we  in  4  byte enables for the config write
- cfg_di  in  32  config write data
- cfg_ready  out  1  config write accepted
- cfg_do  out  32  config readback, combinational from m_cfgreg_do
- m_valid  out  1  to spimemio valid
- m_addr  out  ADDR_W  to spimemio addr
- m_ready  in  1  from spimemio ready
- m_rdata  in  32  from spimemio rdata
- m_cfgreg_we  out  4  to spimemio cfgreg_we
- m_cfgreg_di  out  32  to spimemio cfgreg_di
- m_cfgreg_do  in  32  from spimemio cfgreg_do
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse when a grant times out

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values:
  - state=IDLE, last=D (so I wins the first tie), wdog=0.
  - All ready outputs, m_valid, m_cfgreg_we, busy and timeout_err are 0.
  - m_addr and m_cfgreg_di are 0.
  - Reset asserted mid-grant aborts the grant with no ready pulse.
- States: IDLE, GNT_I, GNT_D, CFG.
- IDLE, priority evaluated each cycle:
  1. cfg_valid && cfg_we!=0 -> CFG.
  2. i_valid && d_valid -> grant the requester != last.
  3. Otherwise the single valid requester.
  4. None -> stay in IDLE.
  - The transition costs 1 cycle; m_valid=0 in IDLE.
  - cfg_valid with cfg_we==0 -> cfg_ready=1 for 1 cycle in IDLE, no write issued.
- GNT_x (x = I or D):
  - m_valid = x_valid; m_addr = x_addr, combinational mux by state.
  - x_ready = m_ready and x_rdata = m_rdata, combinational. The other requester's ready stays 0.
  - On m_ready: last<=x, state<=IDLE, wdog<=0.
  - If x_valid drops before m_ready (protocol violation): state<=IDLE, no ready, last unchanged.
  - The grant is never preempted, including by cfg_valid.
- Watchdog:
  - wdog is an 8-bit counter that increments each GNT cycle without m_ready.
  - When wdog==TIMEOUT and m_ready==0: x_ready=1, x_rdata=ERR_DATA, timeout_err=1, state<=IDLE, last<=x.
  - m_ready in the same cycle takes precedence: normal completion, no error.
- CFG:
  - Lasts exactly 1 cycle: m_cfgreg_we=cfg_we, m_cfgreg_di=cfg_di, cfg_ready=1, then IDLE.
  - m_valid=0 during CFG, so spimemio sees no read while its softreset is triggered.
  - m_cfgreg_we is 0 in every other state.
- Minimum spacing: one IDLE cycle between consecutive grants. Throughput is one word per (spimemio latency + 1) cycles.
- i_rdata and d_rdata are don't-care when their ready is 0; the bench must not check them then.

Test Plan:
- Reset, then i_valid=1, i_addr=0x100000; spimemio model gives m_ready 20 cycles after m_valid -> m_addr=0x100000, i_ready pulses once with model data, state back to IDLE, busy=0.
- i_valid and d_valid both asserted from the same cycle, continuously re-requesting -> grants alternate I,D,I,D starting with I; each ready pulses exactly once per grant.
- d grant in progress while cfg_valid=1, cfg_we=4'b1000, cfg_di=0x0000_0000 -> cfg waits until d_ready, then one IDLE, then a 1-cycle m_cfgreg_we=4'b1000 with cfg_ready=1 and m_valid=0.
- Model never asserts m_ready, TIMEOUT=16 -> i_ready=1 with i_rdata=0xFFFFFFFF and timeout_err=1 on the 17th GNT_I cycle; next request is served normally.
- Assert reset for 1 cycle during GNT_D -> next cycle state=IDLE, all outputs 0, no d_ready pulse; the pending i_valid is granted first.
- cfg_valid=1 with cfg_we=0 -> cfg_ready pulses in IDLE, m_cfgreg_we stays 0.
